// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for a single-port word memory.
// Sub-word stores become an atomic read-modify-write; out-of-range words return an error.
module dmem_arbiter #(
  parameter int DEPTH = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_we,
  input  logic [1:0][3:0]  req_be,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  output logic [1:0]       resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read_en,
  output logic             mem_write_en,
  input  logic [31:0]      mem_rdata,
  output logic [1:0]       dbg_state
);

  // Handshake: a requester raises req_valid[p] with stable fields and holds them
  // until it sees req_ready[p]=1; the request is taken at that clock edge. Exactly
  // one resp_valid[p] pulse follows each accepted request (unless reset intervenes).

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      state_q, state_d;
  logic        port_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [29:0] word_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;   // read data for responses, merged word for RMW
  logic        last_q;   // port granted most recently

  logic        grant_any;
  logic        grant_port;
  logic        addr_err;
  logic        partial;
  logic [31:0] merged;

  // Address bits [1:0] are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[0][1:0], req_addr[1][1:0]};

  assign addr_err  = (word_q >= DEPTH_W);
  assign partial   = (be_q != 4'hF) && (be_q != 4'h0);
  assign dbg_state = state_q;

  always_comb begin
    grant_any  = |req_valid;
    grant_port = 1'b0;
    if (req_valid == 2'b11) grant_port = ~last_q;
    else                    grant_port = req_valid[1];
  end

  always_comb begin
    merged = '0;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : mem_rdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 2'b00;
    resp_valid   = 2'b00;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready[grant_port] = 1'b1;
          state_d               = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr = {word_q, 2'b00};
        state_d  = RESP;
        if (!addr_err) begin
          if (!we_q) begin
            mem_read_en = 1'b1;
          end else if (be_q == 4'hF) begin
            mem_write_en = 1'b1;
            mem_wdata    = wdata_q;
          end else if (partial) begin
            mem_read_en = 1'b1;
            state_d     = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_addr     = {word_q, 2'b00};
        mem_write_en = 1'b1;
        mem_wdata    = data_q;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid[port_q] = 1'b1;
        resp_err           = addr_err;
        resp_rdata         = (!we_q && !addr_err) ? data_q : 32'h0;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must not let an in-flight access commit or a response escape.
    if (reset) begin
      req_ready    = 2'b00;
      resp_valid   = 2'b00;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      mem_wdata    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            port_q  <= grant_port;
            we_q    <= req_we[grant_port];
            be_q    <= req_be[grant_port];
            word_q  <= req_addr[grant_port][31:2];
            wdata_q <= req_wdata[grant_port];
          end
        end
        ACCESS: begin
          if (!addr_err) begin
            if (!we_q)        data_q <= mem_rdata;
            else if (partial) data_q <= merged;
          end
        end
        RESP: last_q <= port_q;
        default: ;
      endcase
    end
  end

endmodule
